// File: rtl/cdb_pkg.sv
// Shared CDB definitions: field layout, reserved tag, statistics selects and the packed CDB word.
// Used by the arbiter, FUs, tagged register file and jump handler.
package cdb_pkg;

    localparam int CDB_TAG_W     = 8;
    localparam int CDB_DATA_W    = 32;
    localparam int CDB_W         = 1 + CDB_TAG_W + CDB_DATA_W;
    localparam int CDB_VALID_BIT = CDB_TAG_W + CDB_DATA_W;
    localparam int CDB_TAG_LSB   = CDB_DATA_W;
    localparam int CDB_VALUE_LSB = 0;

    // Tag 0 marks a register whose value is ready; it must never be broadcast as valid.
    localparam int TAG_READY = 0;

    localparam logic [4:0] SEL_CONFLICT = 5'd30;
    localparam logic [4:0] SEL_IDLE     = 5'd31;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } cdb_word_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (&cnt) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Requester-side CDB bus: per-channel requests and payloads in, grant and broadcast word out.
interface cdb_rr_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
);
    logic [NUM_CH-1:0]                req;
    logic [NUM_CH*(TAG_W+DATA_W)-1:0] payload;
    logic [NUM_CH-1:0]                grant;
    logic [TAG_W+DATA_W:0]            cdb;

    modport master (output req, output payload, input grant, input cdb);
    modport slave  (input req, input payload, output grant, output cdb);
endinterface

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit,
// then rotate the winner back to an absolute channel index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic [N-1:0] rot;
    logic         found;
    int           first;
    int           idx_abs;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        rot       = N'({req, req} >> ptr);
        found     = 1'b0;
        first     = 0;
        idx_abs   = 0;
        grant     = '0;
        grant_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                first = j;
            end
        end
        idx_abs = first + int'(ptr);
        if (idx_abs >= N) idx_abs = idx_abs - N;
        for (int j = 0; j < N; j++) begin
            grant[j] = found && (j == idx_abs);
        end
        grant_idx = IDX_W'(idx_abs);
    end
endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter with a registered one-cycle {valid, tag, value} broadcast.
// Optional statistics counters are built when CDB_STATS_EN is defined.
module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    cdb_rr_arbiter_if.slave         bus,
    output logic                    tag0_err,
    input  logic [4:0]              debug_sel,
    output logic [31:0]             debug_cnt
);
    localparam int SLOT_W = TAG_W + DATA_W;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [NUM_CH-1:0] pick_grant;
    logic              any_grant;
    logic [SLOT_W-1:0] slot;
    logic [TAG_W-1:0]  slot_tag;
    logic              tag_ok;
    logic [SLOT_W:0]   cdb_q;

    rr_pick #(.N(NUM_CH), .IDX_W(IDX_W)) u_pick (
        .req       (bus.req),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (grant_idx)
    );

    assign bus.grant = rst ? '0 : pick_grant;
    assign any_grant = |bus.grant;

    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(grant_idx)) slot = bus.payload[i*SLOT_W +: SLOT_W];
        end
    end

    assign slot_tag = slot[SLOT_W-1 -: TAG_W];
    assign tag_ok   = (slot_tag != TAG_W'(TAG_READY));
    assign next_ptr = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cdb_q    <= '0;
            tag0_err <= 1'b0;
        end else if (any_grant) begin
            cdb_q <= {tag_ok, slot};
            ptr   <= next_ptr;
            if (!tag_ok) tag0_err <= 1'b1;
        end else begin
            cdb_q <= '0;
        end
    end

    assign bus.cdb = cdb_q;

`ifdef CDB_STATS_EN
    logic [31:0] grant_cnt [NUM_CH];
    logic [31:0] conflict_cnt;
    logic [31:0] idle_cnt;

    // NOTE: the counter array is reset element by element, unlike a RAM, because debug reads must start from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) grant_cnt[i] <= '0;
            conflict_cnt <= '0;
            idle_cnt     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.grant[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
            end
            if ($countones(bus.req) >= 2) conflict_cnt <= sat_inc(conflict_cnt);
            if (bus.req == '0)            idle_cnt     <= sat_inc(idle_cnt);
        end
    end

    always_comb begin
        debug_cnt = '0;
        if (debug_sel == SEL_CONFLICT) begin
            debug_cnt = conflict_cnt;
        end else if (debug_sel == SEL_IDLE) begin
            debug_cnt = idle_cnt;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(debug_sel) == i) debug_cnt = grant_cnt[i];
            end
        end
    end
`else
    logic unused_debug_sel;
    assign unused_debug_sel = ^debug_sel;
    assign debug_cnt        = '0;
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Self-checking bench for cdb_rr_arbiter: directed scenarios then randomized held requests,
// compared against a scan-based round-robin reference model.
module tb_cdb_rr_arbiter;
    localparam int N  = 4;
    localparam int SW = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tag0_err;
    logic [4:0]  debug_sel = '0;
    logic [31:0] debug_cnt;

    cdb_rr_arbiter_if #(.NUM_CH(N), .TAG_W(8), .DATA_W(32)) bus ();

    cdb_rr_arbiter #(.NUM_CH(N), .TAG_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tag0_err  (tag0_err),
        .debug_sel (debug_sel),
        .debug_cnt (debug_cnt)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          m_ptr  = 0;
    int          m_last = -1;
    logic [40:0] m_cdb  = '0;
    logic        m_tag0 = 1'b0;
    logic [31:0] m_gcnt [N];
    logic [31:0] m_conf = '0;
    logic [31:0] m_idle = '0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int pick_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*SW-1:0] put(input logic [N*SW-1:0] base, input int ch,
                                            input logic [7:0] tag, input logic [31:0] val);
        base[ch*SW +: SW] = {tag, val};
        return base;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_cdb  = '0;
        m_tag0 = 1'b0;
        m_conf = '0;
        m_idle = '0;
        for (int i = 0; i < N; i++) m_gcnt[i] = '0;
    endtask

    // Drive one cycle between edges, check the combinational grant, then the registered outputs after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N*SW-1:0] p);
        int          idx;
        logic [39:0] sl;
        bus.req     = r;
        bus.payload = p;
        #1;
        idx    = pick_model(r, m_ptr);
        m_last = idx;
        check("grant", 64'(bus.grant), (idx >= 0) ? (64'(1) << idx) : 64'(0));
        @(posedge clk);
        #1;
        if (r == '0) m_idle++;
        if ($countones(r) >= 2) m_conf++;
        if (idx >= 0) begin
            sl    = p[idx*SW +: SW];
            m_cdb = {sl[39:32] != 8'h00, sl};
            if (sl[39:32] == 8'h00) m_tag0 = 1'b1;
            m_ptr = (idx + 1) % N;
            m_gcnt[idx]++;
        end else begin
            m_cdb = '0;
        end
        check("cdb", 64'(bus.cdb), 64'(m_cdb));
        check("tag0_err", 64'(tag0_err), 64'(m_tag0));
    endtask

    task automatic check_stats();
        int          sels [7] = '{0, 1, 2, 3, 5, 30, 31};
        logic [31:0] exp;
        for (int k = 0; k < 7; k++) begin
            debug_sel = 5'(sels[k]);
            #1;
            exp = '0;
`ifdef CDB_STATS_EN
            if (sels[k] < N)        exp = m_gcnt[sels[k]];
            else if (sels[k] == 30) exp = m_conf;
            else if (sels[k] == 31) exp = m_idle;
`endif
            check($sformatf("debug_cnt[%0d]", sels[k]), 64'(debug_cnt), 64'(exp));
        end
        debug_sel = '0;
    endtask

    logic [N*SW-1:0] pl;
    logic [N-1:0]    pend;

    initial begin
        model_reset();
        pl          = '0;
        pend        = '0;
        bus.req     = '1;
        bus.payload = '0;
        #3;
        check("grant_in_reset", 64'(bus.grant), 64'(0));
        check("cdb_in_reset", 64'(bus.cdb), 64'(0));
        check("tag0_in_reset", 64'(tag0_err), 64'(0));
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;

        // Idle from reset
        for (int c = 0; c < 5; c++) step('0, '0);
        check_stats();

        // Single request on ch2, then idle
        pl = put('0, 2, 8'h05, 32'hDEAD_BEEF);
        step(4'b0100, pl);
        check("single_cdb", 64'(bus.cdb), 64'({1'b1, 8'h05, 32'hDEAD_BEEF}));
        step('0, pl);
        check("single_after", 64'(bus.cdb), 64'(0));

        // Full contention: ch3, ch0, ch1, ch2, ch3 given ptr=3 after ch2
        for (int i = 0; i < N; i++) pl = put(pl, i, 8'(8'h10 + i), 32'(32'h1000 + i));
        for (int c = 0; c < 5; c++) step('1, pl);
        check_stats();

        // Pointer wrap with sparse requests: ch3 alone, then ch1 beats ch3 from ptr=0
        step(4'b1000, pl);
        step(4'b1010, pl);
        check("wrap_winner", 64'(m_last), 64'(1));

        // Sole requester on consecutive cycles
        step(4'b0001, pl);
        step(4'b0001, pl);

        // Tag 0 on ch1
        pl = put(pl, 1, 8'h00, 32'h0BAD_0000);
        step(4'b0010, pl);
        check("tag0_valid", 64'(bus.cdb[40]), 64'(0));
        check("tag0_flag", 64'(tag0_err), 64'(1));

        // Randomized held requesters
        for (int i = 0; i < N; i++) pl = put(pl, i, 8'(8'h20 + i), $urandom);
        for (int c = 0; c < 150; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i] = 1'b1;
                    pl = put(pl, i, 8'($urandom_range(255, 1)), $urandom);
                end
            end
            step(pend, pl);
            if (m_last >= 0) begin
                if ($urandom_range(1, 0) == 1) pend[m_last] = 1'b0;
                else pl = put(pl, m_last, 8'($urandom_range(255, 0)), $urandom);
            end
            if (c % 37 == 0) check_stats();
        end
        check_stats();

        // Reset mid-operation
        pl = put(pl, 0, 8'h33, 32'hCAFE_0000);
        step('1, pl);
        rst = 1'b1;
        #1;
        check("cdb_mid_reset", 64'(bus.cdb), 64'(0));
        check("grant_mid_reset", 64'(bus.grant), 64'(0));
        check("tag0_mid_reset", 64'(tag0_err), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step('1, pl);
        check("after_reset_winner", 64'(m_last), 64'(0));
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
